// File: rtl/tx_control_pkg.sv
// tx_control_pkg: shared state encodings and line-select codes for the serial transmitter
package tx_control_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

endpackage

// File: rtl/tx_control_baud_tick.sv
// baud_tick: counts 0..CLKS_PER_BIT-1 and flags the terminal count for one cycle
module baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = cnt_q == LAST;

    // wrap to zero at terminal count, hold at zero while cleared
    always_comb cnt_d = (clear || tick) ? '0 : cnt_q + CW'(1);

    // counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/tx_control.sv
// tx_control: frame sequencer for an 8-bit, parity, one-stop-bit serial transmitter
module tx_control
    import tx_control_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic [1:0] sel,
    output logic       data_bit,
    output logic       parity_bit,
    output logic       busy,
    output logic       done
);

    localparam logic ODD = PARITY_ODD != 0;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic       parity_q, parity_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       clear, tick;

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .tick  (tick)
    );

    assign data_bit   = shift_q[0];
    assign parity_bit = parity_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // line source decoded from the registered state only
    always_comb
        sel = state_q == START  ? SEL_START  :
              state_q == DATA   ? SEL_DATA   :
              state_q == PARITY ? SEL_PARITY : SEL_STOP;

    // next-state, shift and counter logic; baud counter held clear while idle
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        clear    = 1'b0;
        case (state_q)
            IDLE: begin
                clear = 1'b1;
                if (tx_start) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    bit_d    = '0;
                    parity_d = ^tx_data ^ ODD;
                end
            end
            START:  if (tick) state_d = DATA;
            DATA: if (tick) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (tick) state_d = STOP;
            STOP: if (tick) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // state and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            parity_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            parity_q <= parity_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end

endmodule

// File: tb/tb_tx_control.sv
// tb_tx_control: directed checks of framing, parity, back-to-back and reset behaviour
module tb_tx_control;
    import tx_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st  [3];
    logic [7:0] dat [3];
    logic [1:0] sl  [3];
    logic       db  [3];
    logic       pb  [3];
    logic       bz  [3];
    logic       dn  [3];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    tx_control #(.CLKS_PER_BIT(16), .PARITY_ODD(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .tx_start(st[0]), .tx_data(dat[0]),
        .sel(sl[0]), .data_bit(db[0]), .parity_bit(pb[0]), .busy(bz[0]), .done(dn[0])
    );

    tx_control #(.CLKS_PER_BIT(16), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .tx_start(st[1]), .tx_data(dat[1]),
        .sel(sl[1]), .data_bit(db[1]), .parity_bit(pb[1]), .busy(bz[1]), .done(dn[1])
    );

    tx_control #(.CLKS_PER_BIT(2), .PARITY_ODD(0)) dut_fast (
        .clk(clk), .rst_n(rst_n), .tx_start(st[2]), .tx_data(dat[2]),
        .sel(sl[2]), .data_bit(db[2]), .parity_bit(pb[2]), .busy(bz[2]), .done(dn[2])
    );

    // downstream 4:1 line selector
    function automatic logic line_of(input int d);
        return sl[d] == SEL_START  ? 1'b0  :
               sl[d] == SEL_DATA   ? db[d] :
               sl[d] == SEL_PARITY ? pb[d] : 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check($sformatf("%s sel[%0d]", tag, d), sl[d], SEL_STOP);
        check($sformatf("%s busy[%0d]", tag, d), bz[d], 0);
        check($sformatf("%s done[%0d]", tag, d), dn[d], 0);
        check($sformatf("%s data_bit[%0d]", tag, d), db[d], 0);
        check($sformatf("%s parity_bit[%0d]", tag, d), pb[d], 0);
    endtask

    // called at the negedge before the accepting posedge; returns at the done-cycle negedge
    task automatic check_frame(input int d, input int n, input logic [7:0] data, input logic odd, input logic hold);
        logic [10:0] f;
        f = {1'b1, ^data ^ odd, data, 1'b0};
        for (int k = 0; k < 11 * n; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) st[d] = 1'b0;
            check($sformatf("line[%0d] data %0h cyc %0d", d, data, k), line_of(d), f[k / n]);
            check($sformatf("busy[%0d] data %0h cyc %0d", d, data, k), bz[d], 1);
            check($sformatf("done[%0d] data %0h cyc %0d", d, data, k), dn[d], 0);
        end
        @(negedge clk);
        check($sformatf("end done[%0d] data %0h", d, data), dn[d], 1);
        check($sformatf("end busy[%0d] data %0h", d, data), bz[d], 0);
        check($sformatf("end sel[%0d] data %0h", d, data), sl[d], SEL_STOP);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            st[i]  = 1'b0;
            dat[i] = 8'h00;
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check_idle(i, "reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single frame 0xA5, even parity
        st[0] = 1'b1; dat[0] = 8'hA5;
        check_frame(0, 16, 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        check("done drops", dn[0], 0);

        // odd parity of 0x00
        st[1] = 1'b1; dat[1] = 8'h00;
        check_frame(1, 16, 8'h00, 1'b1, 1'b0);
        check("odd parity 00", pb[1], 1);

        // even parity of 0xFF
        st[0] = 1'b1; dat[0] = 8'hFF;
        check_frame(0, 16, 8'hFF, 1'b0, 1'b0);
        check("even parity FF", pb[0], 0);
        @(negedge clk);

        // tx_start held high: back-to-back frames with one done/idle cycle between
        st[0] = 1'b1; dat[0] = 8'h3C;
        check_frame(0, 16, 8'h3C, 1'b0, 1'b1);
        dat[0] = 8'hC3;
        check_frame(0, 16, 8'hC3, 1'b0, 1'b0);
        @(negedge clk);
        check("idle after b2b", bz[0], 0);

        // reset in the middle of data bit 4
        st[0] = 1'b1; dat[0] = 8'h5A;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (84) @(negedge clk);
        check("pre-reset sel", sl[0], SEL_DATA);
        check("pre-reset bit4", db[0], 1);
        check("pre-reset busy", bz[0], 1);
        rst_n = 1'b0;
        #1;
        check_idle(0, "async reset");
        @(negedge clk);
        check_idle(0, "held reset");
        rst_n = 1'b1;
        st[0] = 1'b1; dat[0] = 8'h96;
        check_frame(0, 16, 8'h96, 1'b0, 1'b0);

        // minimum bit period
        st[2] = 1'b1; dat[2] = 8'h01;
        check_frame(2, 2, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        check("fast done drops", dn[2], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_control.md
TX_CONTROL -- requirements
Module: tx_control

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port tx_start, input, 1 bit: request to send one frame.
REQ-006 SHALL have port tx_data, input, 8 bits: byte to send; sampled only on accept.
REQ-007 SHALL have port sel, output, 2 bits: line-source select for the downstream 4:1 bit selector. Codes: 00 = start (line 0), 01 = data_bit, 10 = parity_bit, 11 = stop/idle (line 1).
REQ-008 SHALL have port data_bit, output, 1 bit: current data bit, LSB first.
REQ-009 SHALL have port parity_bit, output, 1 bit: parity of the latched byte.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
- sel per state: IDLE = 11, START = 00, DATA = 01, PARITY = 10, STOP = 11.
REQ-013 SHALL accept a request only when state == IDLE and tx_start == 1 at a clock edge.
- On accept: latch tx_data into a shift register, compute parity_bit, clear the baud and bit counters, enter START.
REQ-014 SHALL ignore tx_start in every state other than IDLE; no queuing.
REQ-015 SHALL hold each of START, each DATA bit, PARITY and STOP for exactly CLKS_PER_BIT cycles, timed by a baud counter running 0..CLKS_PER_BIT-1.
REQ-016 SHALL advance on the baud-counter terminal count; the counter wraps to 0.
REQ-017 SHALL transmit 8 data bits, LSB first, using a 3-bit bit counter.
- data_bit = shift_reg[0]; the register shifts right at each DATA bit boundary.
- Leave DATA after bit counter == 7 reaches terminal count.
REQ-018 SHALL set parity_bit = XOR(tx_data) XOR PARITY_ODD, held constant from accept until the next accept.
REQ-019 SHALL assert busy from the cycle after accept through the last STOP cycle: exactly 11*CLKS_PER_BIT cycles per frame.
REQ-020 SHALL pulse done high for exactly one cycle: the first cycle back in IDLE after STOP.
REQ-021 SHALL accept a tx_start that is high during that done cycle, so back-to-back frames have zero idle gap beyond that one cycle.
REQ-022 SHALL keep data_bit a registered value, stable for the whole bit period, with no glitch at bit boundaries.

Reset
REQ-023 SHALL, on rst_n low (asynchronous), immediately force:
- state = IDLE, sel = 11
- data_bit = 0, parity_bit = 0
- busy = 0, done = 0
- all counters and the shift register = 0.
REQ-024 SHALL abort any in-progress frame on reset mid-frame; the line returns to idle (sel = 11) with no done pulse.
REQ-025 SHALL leave reset cleanly: the first tx_start is accepted at the first rising edge after rst_n deasserts.

Structure
REQ-026 SHALL place the following in a shared definitions file used by tx_control, the bit selector, and benches:
- state encodings
- sel codes (SEL_START, SEL_DATA, SEL_PARITY, SEL_STOP)
REQ-027 SHALL implement the baud counter as sub-module baud_tick.
- Inputs: clk, rst_n, clear.
- Output: tick, one cycle at terminal count.
- Parameter: CLKS_PER_BIT.
REQ-028 SHALL contain all FSM, counter and shift logic in tx_control; no combinational outputs except sel, which is decoded from registered state.

Verification
The bench models the downstream selector: 00→0, 01→data_bit, 10→parity_bit, 11→1.

REQ-029 Single frame, N = 16, tx_data = 0xA5:
- Line sequence: 0, then 1,0,1,0,0,1,0,1, then parity 0, then 1, each held 16 cycles.
- busy high for 176 cycles; done pulses once.
REQ-030 PARITY_ODD = 1, tx_data = 0x00 → parity_bit = 1. tx_data = 0xFF with even parity → parity_bit = 0.
REQ-031 tx_start held high continuously with data 0x3C then 0xC3:
- Two frames separated by exactly one IDLE/done cycle.
- tx_start pulses during busy are ignored.
REQ-032 rst_n pulsed low during DATA bit 4:
- Same cycle: sel = 11, busy = 0.
- No done pulse.
- Next tx_start yields a complete, correct frame.
REQ-033 N = 2 (minimum), tx_data = 0x01:
- Frame lasts 22 cycles.
- data_bit sequence 1,0,0,0,0,0,0,0, each held 2 cycles.
